// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM-stage core and a debug/loader port.
// Define DMEM_ARB_FAIRNESS_EN to enable the forced debug grant after MAX_WAIT blocked cycles.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_valid,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ready,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic {ST_IDLE, ST_WAIT} wait_st_e;

  wait_st_e            state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic core_req;
  logic force_grant;
  logic gnt_dbg;
  logic blocked;

  assign core_req = core_rd | core_wr;

`ifdef DMEM_ARB_FAIRNESS_EN
  assign force_grant = (wait_cnt_q == MAX_WAIT_C);
`else
  assign force_grant = 1'b0;
`endif

  assign gnt_dbg = dbg_valid & (~core_req | force_grant);
  assign blocked = dbg_valid & ~gnt_dbg;

  // Memory read data goes straight back to the core; memory resolves rd+wr as a write.
  assign core_rdata = mem_rdata;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and synthesis cannot infer a latch.
  always_comb begin
    mem_rd     = core_rd;
    mem_wr     = core_wr;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_func3  = core_func3;
    dbg_ready  = 1'b0;
    core_stall = 1'b0;
    if (gnt_dbg) begin
      mem_rd     = ~dbg_we;
      mem_wr     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_func3  = 3'b010;
      dbg_ready  = 1'b1;
      core_stall = core_req;
    end
  end

  // Counts consecutive cycles the debug request has been refused.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (blocked) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!blocked) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    dbg_rvalid_d = gnt_dbg & ~dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    stall_cnt_d  = stall_cnt_q;
    if (core_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus constrained-random
// traffic, all compared against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;

  localparam int MAXW  = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd, core_wr, dbg_valid, dbg_we;
  logic [8:0]  core_addr, dbg_addr;
  logic [31:0] core_wdata, dbg_wdata;
  logic [2:0]  core_func3;
  logic [31:0] core_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        core_stall, dbg_ready, dbg_rvalid, mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_func3;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  // Environment memory driven only by the DUT's memory port.
  logic [31:0] mem [512];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [512];
  int          run;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  int          exp_scnt;
  logic        last_g, last_stall, last_ready_obs;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; exp_rvalid = 1'b0; exp_rdata = '0; exp_scnt = 0;
    last_g = 1'b0; last_stall = 1'b0;
  endtask

  task automatic check_regs();
    check("rvalid", dbg_rvalid, exp_rvalid);
    check("rdata", dbg_rdata, exp_rdata);
    check("stall_cnt", stall_cnt, exp_scnt);
    check("wait_cnt", dut.wait_cnt_q, (run > MAXW) ? MAXW : run);
  endtask

  task automatic step(input logic c_rd, input logic c_wr, input logic [8:0] c_addr,
                      input logic [31:0] c_wd, input logic [2:0] c_f3,
                      input logic d_v, input logic d_we, input logic [8:0] d_addr,
                      input logic [31:0] d_wd);
    logic req, g;
    logic [8:0] e_addr;
    @(negedge clk);
    core_rd = c_rd; core_wr = c_wr; core_addr = c_addr; core_wdata = c_wd; core_func3 = c_f3;
    dbg_valid = d_v; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    #1;
    req    = c_rd | c_wr;
    g      = d_v && (!req || (FAIR && run >= MAXW));
    e_addr = g ? d_addr : c_addr;
    check("dbg_ready", dbg_ready, g);
    check("core_stall", core_stall, g && req);
    check("mem_rd", mem_rd, g ? !d_we : c_rd);
    check("mem_wr", mem_wr, g ? d_we : c_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, g ? d_wd : c_wd);
    check("mem_func3", mem_func3, g ? 3'b010 : c_f3);
    check("core_rdata", core_rdata, ref_mem[e_addr]);
    last_ready_obs = dbg_ready;
    @(posedge clk);
    if (d_v && !g) run++; else run = 0;
    exp_rvalid = g && !d_we;
    if (exp_rvalid) exp_rdata = ref_mem[d_addr];
    if (g && d_we) ref_mem[d_addr] = d_wd;
    else if (!g && c_wr) ref_mem[c_addr] = c_wd;
    if (g && req && exp_scnt < SMAX) exp_scnt++;
    last_g = g; last_stall = g && req;
    #1;
    check_regs();
  endtask

  logic        r_crd, r_cwr, r_dv, r_dwe;
  logic [8:0]  r_caddr, r_daddr;
  logic [31:0] r_cwd, r_dwd;
  logic [2:0]  r_cf3;
  int          first_ready;
  logic [31:0] stored;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    reset = 1'b0;
    {core_rd, core_wr, dbg_valid, dbg_we} = '0;
    core_addr = '0; dbg_addr = '0; core_wdata = '0; dbg_wdata = '0; core_func3 = '0;
    model_reset();
    #2;
    check_regs();
    @(negedge clk); reset = 1'b1;

    // Core idle: debug write then read of 0x10.
    step(0, 0, 9'h0, 32'h0, 3'b0, 1, 1, 9'h10, 32'hDEADBEEF);
    step(0, 0, 9'h0, 32'h0, 3'b0, 1, 0, 9'h10, 32'h0);
    check("dir_rdata", dbg_rdata, 32'hDEADBEEF);
    step(0, 0, 9'h0, 32'h0, 3'b0, 0, 0, 9'h0, 32'h0);

    // Continuous core loads against a pending debug read.
    first_ready = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1, 0, 9'(c), 32'h0, 3'b010, first_ready == 0, 0, 9'h10, 32'h0);
      if (last_ready_obs && first_ready == 0) first_ready = c;
    end
    check("force_cycle", first_ready, FAIR ? MAXW + 1 : 0);
    check("force_stalls", stall_cnt, FAIR ? 1 : 0);
    if (first_ready == 0) begin
      step(0, 0, 9'h0, 32'h0, 3'b0, 1, 0, 9'h10, 32'h0);
      check("idle_grant", last_ready_obs, 1'b1);
    end

    // Debug withdraws after two blocked cycles, then re-requests.
    step(1, 0, 9'h3, 32'h0, 3'b0, 1, 0, 9'h5, 32'h0);
    step(1, 0, 9'h3, 32'h0, 3'b0, 1, 0, 9'h5, 32'h0);
    step(1, 0, 9'h3, 32'h0, 3'b0, 0, 0, 9'h5, 32'h0);
    check("withdraw_cnt", dut.wait_cnt_q, 0);
    step(1, 0, 9'h3, 32'h0, 3'b0, 1, 0, 9'h6, 32'h0);
    check("restart_cnt", dut.wait_cnt_q, 1);

    // Core store followed by debug read of the same address.
    stored = 32'hA5A5_1234;
    step(0, 1, 9'h20, stored, 3'b010, 0, 0, 9'h0, 32'h0);
    step(0, 0, 9'h0, 32'h0, 3'b0, 1, 0, 9'h20, 32'h0);
    check("st_ld_rdata", dbg_rdata, stored);

    // Back-to-back reads, then reset lands with a response in flight.
    step(0, 0, 9'h0, 32'h0, 3'b0, 1, 0, 9'h21, 32'h0);
    @(negedge clk);
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h22;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    dbg_valid = 1'b0;
    @(posedge clk); #1;
    check_regs();
    @(negedge clk); reset = 1'b1;
    #1;
    check("post_rst_ready", dbg_ready, 1'b0);

    // Constrained-random traffic respecting both handshakes.
    {r_crd, r_cwr, r_dv, r_dwe} = '0;
    r_caddr = '0; r_daddr = '0; r_cwd = '0; r_dwd = '0; r_cf3 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 19))
            0, 1, 2:  {r_crd, r_cwr} = 2'b11;
            3, 4, 5, 6, 7, 8, 9: {r_crd, r_cwr} = 2'b01;
            default:  {r_crd, r_cwr} = 2'b10;
          endcase
        end else {r_crd, r_cwr} = 2'b00;
        r_caddr = 9'($urandom_range(0, 15));
        r_cwd   = $urandom;
        r_cf3   = 3'($urandom_range(0, 7));
      end
      if (!(r_dv && !last_g)) begin
        r_dv    = $urandom_range(0, 1) == 1;
        r_dwe   = $urandom_range(0, 2) == 0;
        r_daddr = 9'($urandom_range(0, 15));
        r_dwd   = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        r_dv = 1'b0;
      end
      step(r_crd, r_cwr, r_caddr, r_cwd, r_cf3, r_dv, r_dwe, r_daddr, r_dwd);
    end
    if (FAIR) check("stall_sat", stall_cnt, SMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
